// File: rtl/vending_buyer_if.sv
// Purchase-request handshake plus the coin/choose/can_choice bus toward the vending machine.
// master = the buyer; slave = host and machine side.
interface vending_buyer_if;
    logic       req_valid;
    logic [1:0] req_can;
    logic       req_ready;
    logic [1:0] coin_out;
    logic       choose;
    logic [1:0] can_choice;
    logic [1:0] can_out;
    logic       eject_out;
    logic       done;
    logic [1:0] done_status;

    modport master (
        input  req_valid, req_can, can_out, eject_out,
        output req_ready, coin_out, choose, can_choice, done, done_status
    );

    modport slave (
        output req_valid, req_can, can_out, eject_out,
        input  req_ready, coin_out, choose, can_choice, done, done_status
    );
endinterface

// File: rtl/vending_buyer.sv
// Customer-side initiator: pays for one can with coin pulses, selects it,
// waits for the machine's answer and reports the outcome on a done strobe.
module vending_buyer #(
    parameter int GAP_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 15,
    parameter int USE_DIME      = 1
) (
    input  logic             clk,
    input  logic             async_reset_n,
    vending_buyer_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, COIN, GAP, SETTLE, CHOOSE, SELECT, DONE
    } state_t;

    localparam logic [1:0] ST_VENDED  = 2'b00;
    localparam logic [1:0] ST_EJECTED = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_INVALID = 2'b11;

    localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] TO_LAST     = 4'(TIMEOUT - 1);
    localparam bit         DIME_EN     = (USE_DIME != 0);

    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic [1:0] nickels_reg;
    logic [1:0] can_reg;
    logic       req_ready_reg;
    logic [1:0] coin_reg;
    logic       choose_reg;
    logic [1:0] can_choice_reg;
    logic       done_reg;
    logic [1:0] status_reg;
    logic       aborting;

    // A dime is only taken when at least two nickels remain, so the count never wraps.
    function automatic logic [1:0] coin_for(input logic [1:0] n);
        return (DIME_EN && n >= 2'd2) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] left_after(input logic [1:0] n);
        return (DIME_EN && n >= 2'd2) ? n - 2'd2 : n - 2'd1;
    endfunction

    assign aborting = bus.eject_out && (state_reg inside {COIN, GAP, SETTLE, CHOOSE});

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            nickels_reg    <= '0;
            can_reg        <= '0;
            req_ready_reg  <= 1'b1;
            coin_reg       <= 2'b00;
            choose_reg     <= 1'b0;
            can_choice_reg <= 2'b00;
            done_reg       <= 1'b0;
            status_reg     <= 2'b00;
        end else begin
            done_reg   <= 1'b0;
            coin_reg   <= 2'b00;
            choose_reg <= 1'b0;
            if (aborting) begin
                state_reg  <= DONE;
                done_reg   <= 1'b1;
                status_reg <= ST_EJECTED;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.req_valid) begin
                            req_ready_reg <= 1'b0;
                            can_reg       <= bus.req_can;
                            if (bus.req_can == 2'd0) begin
                                nickels_reg <= 2'd0;
                                state_reg   <= DONE;
                                done_reg    <= 1'b1;
                                status_reg  <= ST_INVALID;
                            end else begin
                                state_reg   <= COIN;
                                coin_reg    <= coin_for(bus.req_can);
                                nickels_reg <= left_after(bus.req_can);
                            end
                        end
                    end
                    COIN: begin
                        state_reg <= GAP;
                        cnt_reg   <= '0;
                    end
                    GAP: begin
                        if (cnt_reg == GAP_LAST) begin
                            cnt_reg <= '0;
                            if (nickels_reg != 2'd0) begin
                                state_reg   <= COIN;
                                coin_reg    <= coin_for(nickels_reg);
                                nickels_reg <= left_after(nickels_reg);
                            end else begin
                                state_reg <= SETTLE;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                    SETTLE: begin
                        if (cnt_reg == SETTLE_LAST) begin
                            state_reg  <= CHOOSE;
                            choose_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                    CHOOSE: begin
                        state_reg      <= SELECT;
                        can_choice_reg <= can_reg;
                        cnt_reg        <= '0;
                    end
                    SELECT: begin
                        // A wrong can id without eject is treated as silence.
                        if (bus.can_out == can_reg) begin
                            state_reg      <= DONE;
                            done_reg       <= 1'b1;
                            status_reg     <= ST_VENDED;
                            can_choice_reg <= 2'b00;
                        end else if (bus.eject_out) begin
                            state_reg      <= DONE;
                            done_reg       <= 1'b1;
                            status_reg     <= ST_EJECTED;
                            can_choice_reg <= 2'b00;
                        end else if (cnt_reg == TO_LAST) begin
                            state_reg      <= DONE;
                            done_reg       <= 1'b1;
                            status_reg     <= ST_TIMEOUT;
                            can_choice_reg <= 2'b00;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                    DONE: begin
                        state_reg     <= IDLE;
                        req_ready_reg <= 1'b1;
                    end
                    default: begin
                        state_reg     <= IDLE;
                        req_ready_reg <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready   = req_ready_reg;
    assign bus.coin_out    = coin_reg;
    assign bus.choose      = choose_reg;
    assign bus.can_choice  = can_choice_reg;
    assign bus.done        = done_reg;
    assign bus.done_status = status_reg;
endmodule
